// File: rtl/keccak_seq_pkg.sv
// rtl/keccak_seq_pkg.sv - shared types, constants and mod-5 helpers for the lane sequencer
package keccak_seq_pkg;

  localparam int CW    = 3;
  localparam int LANES = 25;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCAN      = 2'd1,
    ROUND_END = 2'd2,
    DONE      = 2'd3
  } seq_state_t;

  // Step a 0..4 coordinate, wrapping 4 back to 0.
  function automatic logic [CW-1:0] inc_mod5(input logic [CW-1:0] v);
    return (v == 3'd4) ? 3'd0 : v + 3'd1;
  endfunction

  // Reduce a 0..20 sum to 0..4 with a compare ladder instead of a divider.
  function automatic logic [CW-1:0] reduce_mod5(input logic [4:0] s);
    if (s >= 5'd20)      return 3'(s - 5'd20);
    else if (s >= 5'd15) return 3'(s - 5'd15);
    else if (s >= 5'd10) return 3'(s - 5'd10);
    else if (s >= 5'd5)  return 3'(s - 5'd5);
    else                 return 3'(s);
  endfunction

`ifdef KECCAK_LANE_SEQ_ROT_EN
  // Rho offsets indexed by i + 5*j (i = column, j = row).
  localparam logic [5:0] RHO_OFF [LANES] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  function automatic logic [4:0] rho_index(input logic [CW-1:0] i, input logic [CW-1:0] j);
    return 5'(i) + 5'(j) * 5'd5;
  endfunction
`endif

endpackage

// File: rtl/keccak_lane_sequencer_pi_map.sv
// rtl/keccak_lane_sequencer_pi_map.sv - combinational pi lane mapping (i,j) -> (j, (2i+3j) mod 5)
module keccak_pi_map
  import keccak_seq_pkg::*;
(
  input  logic [CW-1:0] i,
  input  logic [CW-1:0] j,
  output logic [CW-1:0] dst_i,
  output logic [CW-1:0] dst_j
);

  logic [4:0] sum;

  // 2i + 3j peaks at 20, so five bits hold it without overflow.
  assign sum   = {1'b0, i, 1'b0} + {2'b00, j} + {1'b0, j, 1'b0};
  assign dst_i = j;
  assign dst_j = reduce_mod5(sum);

endmodule

// File: rtl/keccak_lane_sequencer.sv
// rtl/keccak_lane_sequencer.sv - round/lane walker for the permutation datapath; optional rot_off under KECCAK_LANE_SEQ_ROT_EN
module keccak_lane_sequencer
  import keccak_seq_pkg::*;
#(
  parameter int ROUNDS = 24,
  parameter int RW     = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          lane_ready,
  output logic          lane_valid,
  output logic [2:0]    src_i,
  output logic [2:0]    src_j,
  output logic [2:0]    dst_i,
  output logic [2:0]    dst_j,
  output logic [RW-1:0] round_idx,
  output logic          round_end,
  output logic          busy,
`ifdef KECCAK_LANE_SEQ_ROT_EN
  output logic [5:0]    rot_off,
`endif
  output logic          done
);

  seq_state_t    state_q, state_n;
  logic [CW-1:0] i_q, i_n;
  logic [CW-1:0] j_q, j_n;
  logic [RW-1:0] round_q, round_n;
  logic [CW-1:0] pi_i, pi_j;
  logic          scan_n;

  // Destination is mapped from the next coordinates so the registered
  // src and dst outputs describe the same lane in the same cycle.
  keccak_pi_map u_pi_map (
    .i     (i_n),
    .j     (j_n),
    .dst_i (pi_i),
    .dst_j (pi_j)
  );

  assign scan_n = (state_n == SCAN);

  // State and lane/round counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_n;
      i_q     <= i_n;
      j_q     <= j_n;
      round_q <= round_n;
    end
  end

  // Next state and counter updates; abort overrides everything.
  always_comb begin
    state_n = state_q;
    i_n     = i_q;
    j_n     = j_q;
    round_n = round_q;
    if (abort) begin
      state_n = IDLE;
      i_n     = '0;
      j_n     = '0;
      round_n = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_n = SCAN;
            i_n     = '0;
            j_n     = '0;
            round_n = '0;
          end
        end
        SCAN: begin
          if (lane_ready) begin
            i_n = inc_mod5(i_q);
            if (i_q == 3'd4) begin
              j_n = inc_mod5(j_q);
            end
            if (i_q == 3'd4 && j_q == 3'd4) begin
              state_n = ROUND_END;
            end
          end
        end
        ROUND_END: begin
          if (round_q == RW'(ROUNDS - 1)) begin
            state_n = DONE;
          end else begin
            state_n = SCAN;
            round_n = round_q + RW'(1);
            i_n     = '0;
            j_n     = '0;
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Registered outputs driven from the next state; coordinates read 0 outside SCAN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_valid <= 1'b0;
      src_i      <= '0;
      src_j      <= '0;
      dst_i      <= '0;
      dst_j      <= '0;
      round_idx  <= '0;
      round_end  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      lane_valid <= scan_n;
      src_i      <= scan_n ? i_n  : 3'd0;
      src_j      <= scan_n ? j_n  : 3'd0;
      dst_i      <= scan_n ? pi_i : 3'd0;
      dst_j      <= scan_n ? pi_j : 3'd0;
      round_idx  <= round_n;
      round_end  <= (state_n == ROUND_END);
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
    end
  end

`ifdef KECCAK_LANE_SEQ_ROT_EN
  // Rho offset for the lane being presented, zero whenever no lane is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot_off <= '0;
    end else begin
      rot_off <= scan_n ? RHO_OFF[rho_index(i_n, j_n)] : 6'd0;
    end
  end
`endif

endmodule
